// File: rtl/router_pkg.sv
// router_pkg: router position types, output port indices and XY routing helpers
// shared by the mesh router blocks.
package router_pkg;

    typedef enum logic [3:0] {
        CENTER,
        CORNERNE,
        CORNERNW,
        CORNERSE,
        CORNERSW,
        EDGEN,
        EDGES,
        EDGEE,
        EDGEW
    } router_type;

    typedef enum logic [2:0] {
        PORT_E = 3'd0,
        PORT_W = 3'd1,
        PORT_N = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_e;

    localparam int NPORTS = 5;

    // Bit i set means output port i (E,W,N,S,L order) exists at this position.
    function automatic logic [NPORTS-1:0] port_mask(input router_type rt);
        logic [NPORTS-1:0] m;
        m = '1;
        case (rt)
            CORNERNE: m = 5'b11010;
            CORNERNW: m = 5'b11001;
            CORNERSE: m = 5'b10110;
            CORNERSW: m = 5'b10101;
            EDGEN:    m = 5'b11011;
            EDGES:    m = 5'b10111;
            EDGEE:    m = 5'b11110;
            EDGEW:    m = 5'b11101;
            default:  m = '1;
        endcase
        return m;
    endfunction

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(input logic [31:0] dstX, input logic [31:0] dstY,
                                       input logic [31:0] srcX, input logic [31:0] srcY);
        port_e p;
        if (dstX > srcX)      p = PORT_E;
        else if (dstX < srcX) p = PORT_W;
        else if (dstY > srcY) p = PORT_N;
        else if (dstY < srcY) p = PORT_S;
        else                  p = PORT_L;
        return p;
    endfunction

endpackage

// File: rtl/router_input_sync_fifo.sv
// flit_fifo: synchronous FIFO for router flits; pointers carry an extra wrap bit
// so that full and empty are told apart without a separate counter.
module flit_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [N-1:0]             data_i,
    output logic [N-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0] mem_q [DEPTH];
    logic [AW:0]  wrPtr_q, wrPtr_d;
    logic [AW:0]  rdPtr_q, rdPtr_d;

    always_comb begin
        wrPtr_d = wrPtr_q + {{AW{1'b0}}, push_i};
        rdPtr_d = rdPtr_q + {{AW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q[AW-1:0]] <= data_i;
        end
    end

    assign data_o  = mem_q[rdPtr_q[AW-1:0]];
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign count_o = wrPtr_q - rdPtr_q;

endmodule

// File: rtl/router_input_sync.sv
// router_input_sync: mesh router input port -- flit FIFO, XY route on the head, output
// stage with req/ack hand-off and a drop path. Define ROUTER_DROP_CNT_EN for drop_cnt.
module router_input_sync
    import router_pkg::*;
#(
    parameter router_type rtype = CORNERNE,
    parameter int N     = 32,
    parameter int XW    = 2,
    parameter int YW    = 2,
    parameter int SRCX  = 2,
    parameter int SRCY  = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    output logic              in_ack,
    input  logic [N-1:0]      in_data,
    output logic [NPORTS-1:0] out_req,
    input  logic [NPORTS-1:0] out_ack,
    output logic [N-1:0]      out_data,
    output logic              drop
`ifdef ROUTER_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [NPORTS-1:0] PORT_MASK = port_mask(rtype);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    logic [N-1:0]      headData;
    logic              fifoFull, fifoEmpty;
    logic [AW:0]       fifoCount;
    logic              push, pop, loadNow, dropNow, stageFree, stageXfer, headOk;
    port_e             headPort;
    logic [NPORTS-1:0] headOneHot;
    logic [AW+1:0]     occNext;

    logic [NPORTS-1:0] outReq_q, outReq_d;
    logic [N-1:0]      outData_q, outData_d;
    logic              inAck_q, inAck_d;
    logic              drop_q;

    flit_fifo #(.N(N), .DEPTH(DEPTH)) fifo_u (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_data),
        .data_o  (headData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    always_comb begin
        headPort = xy_route(32'(headData[N-1 -: XW]), 32'(headData[N-XW-1 -: YW]),
                            32'(SRCX), 32'(SRCY));
        headOneHot = '0;
        headOneHot[headPort] = 1'b1;
    end

    // A head bound for a missing port leaves the FIFO at once, whatever the stage holds.
    assign headOk    = (headOneHot & PORT_MASK) != '0;
    assign stageXfer = (outReq_q & out_ack) != '0;
    assign stageFree = (outReq_q == '0) || stageXfer;
    assign dropNow   = !fifoEmpty && !headOk;
    assign loadNow   = !fifoEmpty && headOk && stageFree;
    assign pop       = dropNow || loadNow;
    assign push      = in_req && inAck_q && !fifoFull;

    always_comb begin
        outReq_d  = outReq_q;
        outData_d = outData_q;
        if (loadNow) begin
            outReq_d  = headOneHot;
            outData_d = headData;
        end else if (stageXfer) begin
            outReq_d  = '0;
        end
        occNext = {1'b0, fifoCount} + {{(AW+1){1'b0}}, push} - {{(AW+1){1'b0}}, pop};
        inAck_d = occNext < DEPTH_W;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outReq_q  <= '0;
            outData_q <= '0;
            inAck_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            outReq_q  <= outReq_d;
            outData_q <= outData_d;
            inAck_q   <= inAck_d;
            drop_q    <= dropNow;
        end
    end

`ifdef ROUTER_DROP_CNT_EN
    logic [15:0] dropCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dropCnt_q <= '0;
        end else if (dropNow && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_q <= dropCnt_q + 16'd1;
        end
    end

    assign drop_cnt = dropCnt_q;
`endif

    assign in_ack   = inAck_q;
    assign out_req  = outReq_q;
    assign out_data = outData_q;
    assign drop     = drop_q;

endmodule
